// File: rtl/qupls_ins_window_buffer.sv
// Instruction window buffer between fetch/align and decode: a circular queue of
// up to 4 pushed slots per cycle, presenting the oldest 6 entries as a window.
// Optional macro QUPLS_IBUF_BYPASS_EN: an empty queue forwards the incoming group to the window.
module qupls_ins_window_buffer #(
  parameter int DEPTH = 16,
  parameter int EW    = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_v_i,
  input  logic [2:0]      in_cnt_i,
  input  logic [4*EW-1:0] in_ins_i,
  output logic            in_rdy_o,
  output logic [6*EW-1:0] win_o,
  output logic [2:0]      win_cnt_o,
  input  logic [2:0]      adv_i,
  output logic            err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [2:0]    push_cnt;
  logic          push;
  logic [2:0]    stored_cnt;
  logic          bypass;
  logic [2:0]    adv_a;
  logic          overrun;

  // Accept a group only when room for a full 4-slot group is known from the registered count.
  always_comb begin
    push_cnt   = (in_cnt_i > 3'd4) ? 3'd4 : in_cnt_i;
    in_rdy_o   = rst_i && (count_q <= CW'(DEPTH - 4));
    push       = in_v_i && in_rdy_o && (push_cnt != 3'd0) && !flush_i;
    stored_cnt = (count_q > CW'(6)) ? 3'd6 : count_q[2:0];
`ifdef QUPLS_IBUF_BYPASS_EN
    bypass     = push && (count_q == CW'(0));
`else
    bypass     = 1'b0;
`endif
    if (!rst_i)      win_cnt_o = 3'd0;
    else if (bypass) win_cnt_o = push_cnt;
    else             win_cnt_o = stored_cnt;
    overrun    = (adv_i > win_cnt_o);
    adv_a      = overrun ? win_cnt_o : adv_i;
  end

  // Window view: queued entries from rd_ptr (wrapping), or the incoming group when bypassing.
  always_comb begin
    win_o = '0;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < win_cnt_o) begin
        if (bypass && (i < 4)) win_o[i*EW +: EW] = in_ins_i[i*EW +: EW];
        else                   win_o[i*EW +: EW] = mem_q[rd_ptr_q + PW'(i)];
      end
    end
  end

  // Next-state: bypassed slots are written and retired in the same cycle, so one path covers both builds.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(adv_a);
    wr_ptr_d = wr_ptr_q + (push ? PW'(push_cnt) : PW'(0));
    count_d  = count_q + (push ? CW'(push_cnt) : CW'(0)) - CW'(adv_a);
    err_d    = err_q | overrun;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      err_d    = err_q;
    end
  end

  // Pointer, occupancy and sticky overrun flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Payload storage; no reset needed since unoccupied entries are never shown in the window.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (push && (3'(i) < push_cnt)) begin
        mem_q[wr_ptr_q + PW'(i)] <= in_ins_i[i*EW +: EW];
      end
    end
  end

  assign err_o = err_q;

endmodule
